apb_master: RTL and testbench
=============================

# apb_master

APB requester that drives the 8-bit APB bus used by the team's slave peripherals. It accepts single read/write commands on a valid/ready command port, runs the SETUP → ACCESS sequence, and waits on PREADY. It then returns one response pulse carrying read data and an error flag. It sits between the system-side controller and the APB slaves, one transfer in flight at a time.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: ACCESS-phase wait-state limit, used only when the timeout is compiled in; legal range 1..255.

Ports:
- PCLK  in  1  bus clock; all logic on rising edge.
- PRESETn  in  1  reset: one clock; reset is synchronous and active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when a command can be accepted.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  8  transfer address.
- cmd_wdata  in  8  write data; ignored for reads.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read data, valid with rsp_valid on reads.
- rsp_err  out  1  transfer aborted by timeout, valid with rsp_valid.
- busy  out  1  transfer in flight (SETUP or ACCESS).
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  8  APB address.
- PWDATA  out  8  APB write data.
- PRDATA  in  8  APB read data.
- PREADY  in  1  APB ready / end of wait states.

## Operation
- State machine: IDLE, SETUP, ACCESS. All APB outputs and rsp_* are registered.
- IDLE:
  - cmd_ready = 1.
  - cmd_valid & cmd_ready at an edge latches cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA.
  - The same edge moves the FSM to SETUP.
- SETUP: PSEL=1, PENABLE=0. Unconditionally moves to ACCESS at the next edge.
- ACCESS: PSEL=1, PENABLE=1. Stays in ACCESS while PREADY=0 is sampled.
- On an edge that samples PREADY=1 in ACCESS:
  - FSM goes to IDLE; PSEL and PENABLE go to 0.
  - rsp_valid=1 and rsp_err=0 for exactly one cycle.
  - Read: rsp_rdata takes the PRDATA sampled at that edge.
  - Write: rsp_rdata holds its previous value.
- PADDR, PWRITE and PWDATA stay constant from SETUP through the end of ACCESS. In IDLE they hold their last values; they are not cleared.
- cmd_ready is 0 in SETUP and ACCESS. busy = (state != IDLE).
- Reset:
  - While PRESETn=0, cmd_ready is forced to 0 combinationally.
  - The reset edge sets state=IDLE and clears PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata and rsp_err to 0.
- Reset mid-transfer: the in-flight transfer is dropped, no response is issued, and the bus returns to idle at the reset edge.
- Command changes while not ready are ignored. The only state retained is the latched copy captured at acceptance.

## Timing
- Zero-wait transfer:
  - Accept at edge E0.
  - SETUP during E0..E1.
  - ACCESS during E1..E2, with PREADY sampled at E2.
  - rsp_valid is high during E2..E3, with cmd_ready=1 in the same cycle.
- Back-to-back: a command presented during the rsp_valid cycle is accepted at E3. Minimum period is 3 cycles per transfer.
- Each PREADY=0 cycle in ACCESS adds one cycle of latency.
- rsp_valid never coincides with PSEL=1.

## Configuration
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to ACCESS and increments on each ACCESS edge that samples PREADY=0.
  - When an edge samples PREADY=0 with the counter already at TIMEOUT_CYCLES-1, the transfer aborts: FSM goes to IDLE and PSEL/PENABLE go to 0.
  - The abort response is rsp_valid=1, rsp_err=1, rsp_rdata=8'h00.
  - PREADY=1 on the same edge as the limit wins: normal completion, rsp_err=0.
- Undefined: no counter; ACCESS waits indefinitely; rsp_err is constant 0.

## Test plan
- Reset held 2 cycles mid-ACCESS → PSEL=PENABLE=rsp_valid=0, PADDR=PWDATA=8'h00, cmd_ready=0 during reset and 1 after, no response issued.
- Write addr 8'h05 data 8'hA5, PREADY=1 → PSEL rises 1 cycle after accept, PENABLE 1 cycle later, PWRITE=1, PADDR=8'h05, PWDATA=8'hA5 stable; rsp_valid pulse 3 cycles after accept, rsp_err=0.
- Read 8'h05 with PRDATA=8'hA5 and PREADY low for 3 ACCESS cycles → ACCESS lasts 4 cycles, rsp_rdata=8'hA5, rsp_valid pulse 6 cycles after accept.
- Two writes (8'h01→8'h11, 8'h02→8'h22) with cmd_valid held high → accepts exactly 3 cycles apart, PSEL low for the single cycle between transfers.
- cmd_addr/cmd_wdata toggled every cycle during SETUP/ACCESS → PADDR/PWDATA unchanged; cmd_ready=0 throughout.
- APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY stuck 0 → abort after 4 ACCESS cycles with rsp_err=1 and rsp_rdata=8'h00; repeat with PREADY=1 on the 4th edge → normal completion, rsp_err=0.

Source files
------------

// File: rtl/apb_master.sv
// APB requester: single valid/ready command in, SETUP/ACCESS on the bus, one response pulse out.
// Optional ACCESS wait-state timeout is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [7:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_err,
   output logic       busy,
   output logic       PSEL,
   output logic       PENABLE,
   output logic       PWRITE,
   output logic [7:0] PADDR,
   output logic [7:0] PWDATA,
   input  logic [7:0] PRDATA,
   input  logic       PREADY
);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   state_t state;
   state_t state_next;
   logic   accept;
   logic   done;
   logic   abort;

   if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_timeout_range
      $error("apb_master: TIMEOUT_CYCLES must be in 1..255");
   end

`ifdef APB_MASTER_TIMEOUT_EN
   localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] wait_cnt;
`endif

   // Ready is gated by PRESETn directly so it drops the moment reset asserts.
   assign cmd_ready = PRESETn & (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      done       = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               accept     = 1'b1;
               state_next = SETUP;
            end
         end
         SETUP: begin
            state_next = ACCESS;
         end
         ACCESS: begin
            if (PREADY) begin
               done       = 1'b1;
               state_next = IDLE;
            end
`ifdef APB_MASTER_TIMEOUT_EN
            else if (wait_cnt == LIMIT) begin
               abort      = 1'b1;
               state_next = IDLE;
            end
`endif
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Bus controls are registered from the next state so they line up with the phase.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         PSEL      <= (state_next != IDLE);
         PENABLE   <= (state_next == ACCESS);
         rsp_valid <= done | abort;
         if (accept) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
         end
         if (done && !PWRITE) begin
            rsp_rdata <= PRDATA;
         end else if (abort) begin
            rsp_rdata <= '0;
         end
      end
   end

`ifdef APB_MASTER_TIMEOUT_EN
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         wait_cnt <= '0;
         rsp_err  <= 1'b0;
      end else begin
         rsp_err <= abort;
         if (state == SETUP) begin
            wait_cnt <= '0;
         end else if ((state == ACCESS) && !PREADY) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
      end
   end
`else
   assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Directed self-checking bench for apb_master; timeout cases run when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master;

   logic       PCLK;
   logic       PRESETn;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [7:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       busy;
   logic       PSEL;
   logic       PENABLE;
   logic       PWRITE;
   logic [7:0] PADDR;
   logic [7:0] PWDATA;
   logic [7:0] PRDATA;
   logic       PREADY;

   int unsigned checks;
   int unsigned errors;

   apb_master #(.TIMEOUT_CYCLES(4)) dut (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and let the registered outputs settle.
   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      PRESETn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 8'h00;
      cmd_wdata = 8'h00;
      PRDATA    = 8'h00;
      PREADY    = 1'b0;
      #1;
      check("ready_in_reset_pre", cmd_ready, 1'b0);
      tick();
      tick();
      check("rst_psel", PSEL, 1'b0);
      check("rst_penable", PENABLE, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_paddr", PADDR, 8'h00);
      check("rst_pwdata", PWDATA, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_ready", cmd_ready, 1'b0);
      PRESETn = 1'b1;
      #1;
      check("ready_after_rst", cmd_ready, 1'b1);

      // Zero-wait write 05 <- A5
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h05; cmd_wdata = 8'hA5; PREADY = 1'b1;
      tick();
      cmd_valid = 1'b0; cmd_addr = 8'hFF; cmd_wdata = 8'h00;
      check("wr_setup_psel", PSEL, 1'b1);
      check("wr_setup_penable", PENABLE, 1'b0);
      check("wr_setup_pwrite", PWRITE, 1'b1);
      check("wr_setup_paddr", PADDR, 8'h05);
      check("wr_setup_pwdata", PWDATA, 8'hA5);
      check("wr_setup_ready", cmd_ready, 1'b0);
      check("wr_setup_busy", busy, 1'b1);
      tick();
      check("wr_access_psel", PSEL, 1'b1);
      check("wr_access_penable", PENABLE, 1'b1);
      check("wr_access_paddr", PADDR, 8'h05);
      check("wr_access_pwdata", PWDATA, 8'hA5);
      check("wr_access_rsp", rsp_valid, 1'b0);
      tick();
      check("wr_rsp_valid", rsp_valid, 1'b1);
      check("wr_rsp_err", rsp_err, 1'b0);
      check("wr_rsp_psel", PSEL, 1'b0);
      check("wr_rsp_ready", cmd_ready, 1'b1);
      check("wr_idle_paddr_hold", PADDR, 8'h05);
      tick();
      check("wr_rsp_pulse_end", rsp_valid, 1'b0);

      // Read 05 with three wait states; PRDATA is only valid on the ready edge
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h05; PREADY = 1'b0; PRDATA = 8'h3C;
      tick();
      cmd_valid = 1'b0;
      check("rd_setup_pwrite", PWRITE, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rd_wait_penable", PENABLE, 1'b1);
         check("rd_wait_rsp", rsp_valid, 1'b0);
      end
      PREADY = 1'b1; PRDATA = 8'hA5;
      tick();
      PRDATA = 8'h00;
      check("rd_rsp_valid", rsp_valid, 1'b1);
      check("rd_rsp_rdata", rsp_rdata, 8'hA5);
      check("rd_rsp_psel", PSEL, 1'b0);
      tick();
      check("rd_pulse_end", rsp_valid, 1'b0);
      check("rd_rdata_hold", rsp_rdata, 8'hA5);

      // Back-to-back writes with cmd_valid held high
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h01; cmd_wdata = 8'h11; PREADY = 1'b1;
      tick();
      cmd_addr = 8'h02; cmd_wdata = 8'h22;
      check("b2b_first_paddr", PADDR, 8'h01);
      tick();
      check("b2b_first_pwdata", PWDATA, 8'h11);
      tick();
      check("b2b_first_rsp", rsp_valid, 1'b1);
      check("b2b_gap_psel", PSEL, 1'b0);
      check("b2b_write_keeps_rdata", rsp_rdata, 8'hA5);
      tick();
      cmd_valid = 1'b0;
      check("b2b_second_psel", PSEL, 1'b1);
      check("b2b_second_paddr", PADDR, 8'h02);
      check("b2b_second_pwdata", PWDATA, 8'h22);
      check("b2b_second_rsp_low", rsp_valid, 1'b0);
      tick();
      tick();
      check("b2b_second_rsp", rsp_valid, 1'b1);
      tick();

      // Command bus churns while a transfer is in flight
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_wdata = 8'h55; PREADY = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         cmd_addr  = 8'h40 ^ 8'(8'h11 * (i + 1));
         cmd_wdata = 8'h55 ^ 8'(8'h0F * (i + 1));
         tick();
         check("churn_paddr", PADDR, 8'h40);
         check("churn_pwdata", PWDATA, 8'h55);
         check("churn_ready", cmd_ready, 1'b0);
      end
      cmd_valid = 1'b0; PREADY = 1'b1;
      tick();
      check("churn_rsp", rsp_valid, 1'b1);
      tick();
      check("churn_no_reaccept", PSEL, 1'b0);

`ifdef APB_MASTER_TIMEOUT_EN
      // PREADY stuck low: abort on the 4th ACCESS edge
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10; PREADY = 1'b0; PRDATA = 8'h99;
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         check("to_wait_penable", PENABLE, 1'b1);
         check("to_wait_rsp", rsp_valid, 1'b0);
      end
      tick();
      check("to_abort_rsp", rsp_valid, 1'b1);
      check("to_abort_err", rsp_err, 1'b1);
      check("to_abort_rdata", rsp_rdata, 8'h00);
      check("to_abort_psel", PSEL, 1'b0);
      tick();
      check("to_abort_pulse_end", rsp_valid, 1'b0);
      check("to_err_pulse_end", rsp_err, 1'b0);

      // PREADY arrives on the limit edge: normal completion wins
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h11; PREADY = 1'b0;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      tick();
      tick();
      PREADY = 1'b1; PRDATA = 8'h5A;
      tick();
      check("to_limit_rsp", rsp_valid, 1'b1);
      check("to_limit_err", rsp_err, 1'b0);
      check("to_limit_rdata", rsp_rdata, 8'h5A);
      tick();
`else
      // Without the timeout a long wait never aborts
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10; PREADY = 1'b0;
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int i = 0; i < 20; i++) tick();
      check("long_wait_psel", PSEL, 1'b1);
      check("long_wait_rsp", rsp_valid, 1'b0);
      PREADY = 1'b1; PRDATA = 8'hC3;
      tick();
      check("long_wait_rsp_done", rsp_valid, 1'b1);
      check("long_wait_err", rsp_err, 1'b0);
      check("long_wait_rdata", rsp_rdata, 8'hC3);
      tick();
`endif

      // Reset held two cycles in the middle of ACCESS
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h77; cmd_wdata = 8'h88; PREADY = 1'b0;
      tick();
      cmd_valid = 1'b0;
      tick();
      check("mid_access_penable", PENABLE, 1'b1);
      PRESETn = 1'b0;
      #1;
      check("mid_rst_ready_comb", cmd_ready, 1'b0);
      tick();
      check("mid_rst_psel", PSEL, 1'b0);
      check("mid_rst_penable", PENABLE, 1'b0);
      check("mid_rst_paddr", PADDR, 8'h00);
      check("mid_rst_pwdata", PWDATA, 8'h00);
      check("mid_rst_rsp", rsp_valid, 1'b0);
      tick();
      check("mid_rst_ready", cmd_ready, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      PRESETn = 1'b1; PREADY = 1'b1;
      #1;
      check("mid_rst_ready_after", cmd_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mid_rst_no_rsp", rsp_valid, 1'b0);
         check("mid_rst_idle_psel", PSEL, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
